// File: rtl/io_seg7_display.sv
// ---------------------------------------------------------------------------
// io_seg7_display
//   Multiplexed four-digit seven-segment driver for the Risc16 io_write_device
//   output. One digit is lit per slot. The displayed value is latched once per
//   full scan, so a scan never mixes an old and a new value. The decimal point
//   of digit 0 marks a scan whose value differs from the previous scan.
//
// Parameters
//   REFRESH_DIV   : clock cycles per digit slot (>= 4)
//   BLANK_CYCLES  : cycles at slot start with all anodes off (< REFRESH_DIV)
//   BLANK_LEADING : 1 = suppress leading zero digits (digit 0 always shown)
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   io_value   in   16-bit value to display (synchronous to clk)
//   display_en in   0 = all anodes off, scanning keeps running
//   an         out  anode selects, active low, an[i] drives digit i
//   seg        out  cathodes {g,f,e,d,c,b,a}, active low
//   dp         out  decimal point, active low
// ---------------------------------------------------------------------------
module io_seg7_display #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_CYCLES  = 16,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_value,
  input  logic        display_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  // Scan state
  logic [CNT_W-1:0] r_slot_cnt;
  logic [1:0]       r_dig;
  logic [15:0]      r_shadow;
  logic             r_chg;

  // Registered display outputs
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_slot_end;
  logic             w_capture;
  logic             w_in_blank;
  logic             w_upper_zero;
  logic             w_lead_blank;
  logic             w_blank;
  logic [3:0]       w_nib;
  logic [3:0]       w_an_sel;

  // Hex glyph, active low {g,f,e,d,c,b,a}; b and d are lowercase.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign w_slot_end = (r_slot_cnt == CNT_W'(REFRESH_DIV - 1));
  // The value is taken only as the last slot of digit 3 ends, so the next
  // scan starts on a fresh, stable copy.
  assign w_capture  = w_slot_end && (r_dig == 2'd3);

  // Anti-ghosting window at the start of every slot.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank_win
      assign w_in_blank = (r_slot_cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_blank_win
      assign w_in_blank = 1'b0;
    end
  endgenerate

  // Current digit's nibble and whether it and every more significant nibble
  // are zero (digit 0 is never treated as leading).
  always_comb begin
    w_nib        = r_shadow[3:0];
    w_upper_zero = 1'b0;
    case (r_dig)
      2'd1: begin
        w_nib        = r_shadow[7:4];
        w_upper_zero = (r_shadow[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib        = r_shadow[11:8];
        w_upper_zero = (r_shadow[15:8] == 8'h00);
      end
      2'd3: begin
        w_nib        = r_shadow[15:12];
        w_upper_zero = (r_shadow[15:12] == 4'h0);
      end
      default: begin
        w_nib        = r_shadow[3:0];
        w_upper_zero = 1'b0;
      end
    endcase
  end

  assign w_lead_blank = (BLANK_LEADING != 0) && w_upper_zero;
  assign w_blank      = w_in_blank || !display_en || w_lead_blank;
  assign w_an_sel     = ~(4'b0001 << r_dig);

  // Stage 0: slot/digit counters and once-per-scan value capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_cnt <= '0;
      r_dig      <= 2'd0;
      r_shadow   <= 16'h0000;
      r_chg      <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_slot_cnt <= '0;
        r_dig      <= r_dig + 2'd1;
      end else begin
        r_slot_cnt <= r_slot_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_shadow <= io_value;
        r_chg    <= (io_value != r_shadow);
      end
    end
  end

  // Stage 1: registered anode/cathode drive from the previous cycle's state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (w_blank) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_sel;
      r_seg <= hex_glyph(w_nib);
      r_dp  <= !((r_dig == 2'd0) && r_chg);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_io_seg7_display.sv
module tb_io_seg7_display;

  localparam int R    = 8;
  localparam int B    = 2;
  localparam int SCAN = 4 * R;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_value;
  logic        display_en;

  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;
  logic        dp1, dp0;

  always #5 clk = ~clk;

  io_seg7_display #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .BLANK_LEADING(1)) dut_lead (
    .clk(clk), .reset(reset), .io_value(io_value), .display_en(display_en),
    .an(an1), .seg(seg1), .dp(dp1)
  );

  io_seg7_display #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .BLANK_LEADING(0)) dut_full (
    .clk(clk), .reset(reset), .io_value(io_value), .display_en(display_en),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  int checks   = 0;
  int failures = 0;

  // Model: e = edges since reset release; displayed value per scan and its
  // change flag are tracked as whole values, position derived from e.
  int          e;
  logic [15:0] m_value;
  logic        m_chg;

  logic [6:0] glyph_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Returns {an, seg, dp} the display must show for time index t.
  function automatic logic [11:0] expect_out(input int t, input logic [15:0] val,
                                             input logic ch, input logic en, input int bl);
    int          slot;
    int          d;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        blank;
    slot  = t % R;
    d     = (t / R) % 4;
    upper = val >> (4 * d);
    nib   = upper[3:0];
    blank = (slot < B) || !en || (bl != 0 && d != 0 && upper == 16'h0);
    if (blank) return {4'b1111, 7'b1111111, 1'b1};
    return {~(4'b0001 << d), glyph_tbl[nib], ~((d == 0) && ch)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%h required=%h", name, e, act, exp);
    end
  endtask

  task automatic model_reset();
    e       = 0;
    m_value = 16'h0000;
    m_chg   = 1'b0;
  endtask

  // Advance one clock and compare both instances against the model.
  task automatic step();
    logic [11:0] x1, x0;
    x1 = expect_out(e, m_value, m_chg, display_en, 1);
    x0 = expect_out(e, m_value, m_chg, display_en, 0);
    if (e % SCAN == SCAN - 1) begin
      m_chg   = (io_value != m_value);
      m_value = io_value;
    end
    @(posedge clk);
    #1;
    e++;
    check("an_lead",  16'(an1),  16'(x1[11:8]));
    check("seg_lead", 16'(seg1), 16'(x1[7:1]));
    check("dp_lead",  16'(dp1),  16'(x1[0]));
    check("an_full",  16'(an0),  16'(x0[11:8]));
    check("seg_full", 16'(seg0), 16'(x0[7:1]));
    check("dp_full",  16'(dp0),  16'(x0[0]));
  endtask

  task automatic go_edge(input int n);
    while (e < n) step();
  endtask

  int nblank;

  initial begin
    reset      = 1'b1;
    io_value   = 16'h0000;
    display_en = 1'b1;
    e          = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_an",  16'(an1),  16'hF);
    check("reset_seg", 16'(seg1), 16'h7F);
    check("reset_dp",  16'(dp1),  16'h1);
    reset = 1'b0;
    model_reset();

    // First scan after reset: "0" on digit 0 during slot cycles 3..8 only.
    go_edge(3);
    check("first_an0",  16'(an1),  16'(4'b1110));
    check("first_seg0", 16'(seg1), 16'(7'b1000000));
    go_edge(8);
    check("first_an0_end", 16'(an1), 16'(4'b1110));
    go_edge(11);
    check("first_an1_blank", 16'(an1), 16'(4'b1111));

    // Asynchronous reset mid-slot while digit 2 is lit on the unblanked instance.
    go_edge(20);
    check("pre_reset_an_full",  16'(an0),  16'(4'b1011));
    check("pre_reset_seg_full", 16'(seg0), 16'(7'b1000000));
    reset = 1'b1;
    #1;
    check("async_reset_an",  16'(an0),  16'hF);
    check("async_reset_seg", 16'(seg0), 16'h7F);
    check("async_reset_dp",  16'(dp0),  16'h1);
    @(posedge clk);
    #1;
    io_value = 16'h8A1F;
    reset    = 1'b0;
    model_reset();

    // Full value shown from the second scan, dp only on that scan.
    go_edge(3);
    check("scan0_old_value", 16'(seg1), 16'(7'b1000000));
    go_edge(35);
    check("full_an_d0",  16'(an1),  16'(4'b1110));
    check("full_seg_d0", 16'(seg1), 16'(7'b0001110));
    check("full_dp_d0",  16'(dp1),  16'(1'b0));
    go_edge(43);
    check("full_an_d1",  16'(an1),  16'(4'b1101));
    check("full_seg_d1", 16'(seg1), 16'(7'b1111001));
    go_edge(51);
    check("full_an_d2",  16'(an1),  16'(4'b1011));
    check("full_seg_d2", 16'(seg1), 16'(7'b0001000));
    go_edge(59);
    check("full_an_d3",  16'(an1),  16'(4'b0111));
    check("full_seg_d3", 16'(seg1), 16'(7'b0000000));
    go_edge(67);
    check("full_dp_next_scan", 16'(dp1), 16'(1'b1));

    // Leading-zero blanking with 0x00b0.
    io_value = 16'h00B0;
    go_edge(99);
    check("lz_seg_d0", 16'(seg1), 16'(7'b1000000));
    check("lz_dp_d0",  16'(dp1),  16'(1'b0));
    go_edge(107);
    check("lz_seg_d1", 16'(seg1), 16'(7'b0000011));
    go_edge(115);
    check("lz_an_d2_lead", 16'(an1), 16'(4'b1111));
    check("lz_an_d2_full", 16'(an0), 16'(4'b1011));
    go_edge(123);
    check("lz_an_d3_lead",  16'(an1),  16'(4'b1111));
    check("lz_an_d3_full",  16'(an0),  16'(4'b0111));
    check("lz_seg_d3_full", 16'(seg0), 16'(7'b1000000));

    // Tear-free capture: change value while digit 1 of the scan is active.
    io_value = 16'h1111;
    go_edge(140);
    io_value = 16'h2222;
    go_edge(155);
    check("tear_old_an_d3",  16'(an1),  16'(4'b0111));
    check("tear_old_seg_d3", 16'(seg1), 16'(7'b1111001));
    go_edge(163);
    check("tear_new_seg_d0", 16'(seg1), 16'(7'b0100100));
    go_edge(187);
    check("tear_new_seg_d3", 16'(seg1), 16'(7'b0100100));

    // Enable gating: 5 cycles low during digit 0's lit window.
    go_edge(194);
    display_en = 1'b0;
    go_edge(195);
    check("en_off_first", 16'(an1), 16'(4'b1111));
    go_edge(199);
    check("en_off_last", 16'(an1), 16'(4'b1111));
    display_en = 1'b1;
    go_edge(200);
    check("en_resume", 16'(an1), 16'(4'b1110));
    go_edge(201);
    check("en_slot_boundary", 16'(an1), 16'(4'b1111));
    go_edge(203);
    check("en_next_digit", 16'(an1), 16'(4'b1101));

    // Blank window across three full scans: 2 dark cycles per slot.
    go_edge(224);
    nblank = 0;
    repeat (3 * SCAN) begin
      step();
      if (an1 == 4'b1111) nblank++;
    end
    check("blank_window_count", 16'(nblank), 16'd24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
